// File: rtl/syndrome_seq_calc.sv
// Sequential Hamming-style syndrome and overall-parity calculator for the ECC decode path.
// Folds LANES codeword bits per cycle and classifies the error once all chunks are consumed.
module syndrome_seq_calc #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] NoisyCodeWord,
    input  logic [1:0]            Codeword_Width,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            column,
    output logic                  parity,
    output logic [1:0]            err_class
);

    localparam int         LG_LANES = $clog2(LANES);
    localparam logic [5:0] DW6      = 6'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [5:0]            n_reg;
    logic [5:0]            cnt_reg;
    logic [5:0]            syn_reg;
    logic                  par_reg;
    logic [5:0]            column_reg;
    logic                  parity_reg;
    logic [1:0]            err_class_reg;

    logic [5:0]            n_dec;
    logic [5:0]            chunks_total;
    logic                  fold_done;
    logic [5:0]            base;
    logic [DATA_WIDTH-1:0] shifted;
    logic [LANES-1:0]      chunk;
    logic [5:0]            lane_col [LANES];
    logic [5:0]            fold_col;
    logic [1:0]            class_next;

    // Active width, clamped so a narrow instance never looks past its own bits.
    always_comb begin
        case (Codeword_Width)
            2'b00:   n_dec = 6'd8;
            2'b01:   n_dec = 6'd16;
            default: n_dec = 6'd32;
        endcase
        if (n_dec > DW6)
            n_dec = DW6;
    end

    assign chunks_total = n_reg >> LG_LANES;
    assign fold_done    = (cnt_reg >= chunks_total);
    assign base         = 6'(cnt_reg << LG_LANES);
    assign shifted      = data_reg >> base;
    assign chunk        = shifted[LANES-1:0];

    // Each lane contributes its 1-based bit position when the bit is set.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_col[gi] = chunk[gi] ? (base + 6'(gi + 1)) : 6'd0;
        end
    endgenerate

    always_comb begin
        fold_col = 6'd0;
        for (int k = 0; k < LANES; k++)
            fold_col = fold_col ^ lane_col[k];
    end

    always_comb begin
        if (!par_reg)
            class_next = (syn_reg == 6'd0) ? 2'b00 : 2'b10;
        else
            class_next = (syn_reg <= n_reg) ? 2'b01 : 2'b11;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = ACCUM;
            ACCUM:   if (fold_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            n_reg         <= 6'd0;
            cnt_reg       <= 6'd0;
            syn_reg       <= 6'd0;
            par_reg       <= 1'b0;
            column_reg    <= 6'd0;
            parity_reg    <= 1'b0;
            err_class_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= NoisyCodeWord;
                        n_reg    <= n_dec;
                        cnt_reg  <= 6'd0;
                        syn_reg  <= 6'd0;
                        par_reg  <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (fold_done) begin
                        column_reg    <= syn_reg;
                        parity_reg    <= par_reg;
                        err_class_reg <= class_next;
                    end else begin
                        syn_reg <= syn_reg ^ fold_col;
                        par_reg <= par_reg ^ (^chunk);
                        cnt_reg <= cnt_reg + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign column    = column_reg;
    assign parity    = parity_reg;
    assign err_class = err_class_reg;

endmodule

// File: tb/tb_syndrome_seq_calc.sv
// Scoreboard bench for syndrome_seq_calc: an 8-lane and a 1-lane instance share reset;
// drivers push hand-computed results, per-instance monitors pop and compare.
module tb_syndrome_seq_calc;

    typedef struct {
        logic [5:0] col;
        logic       par;
        logic [1:0] ec;
        int         lat;
        int         acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  iv = 2'b00;
    logic [1:0]  ordy = 2'b11;
    logic [1:0]  ir, ov;
    logic [31:0] cw_a = '0, cw_b = '0;
    logic [1:0]  w_a = 2'b00, w_b = 2'b00;
    logic [5:0]  col_a, col_b;
    logic        par_a, par_b;
    logic [1:0]  ec_a, ec_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [1:0] prev_ov = 2'b00;
    logic [1:0] prev_hs = 2'b00;
    logic [8:0] held [2];

    syndrome_seq_calc #(.DATA_WIDTH(32), .LANES(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .NoisyCodeWord(cw_a), .Codeword_Width(w_a), .out_valid(ov[0]),
        .out_ready(ordy[0]), .column(col_a), .parity(par_a), .err_class(ec_a));

    syndrome_seq_calc #(.DATA_WIDTH(32), .LANES(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .NoisyCodeWord(cw_b), .Codeword_Width(w_b), .out_valid(ov[1]),
        .out_ready(ordy[1]), .column(col_b), .parity(par_b), .err_class(ec_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(int i);
        exp_t       e;
        logic [5:0] c;
        logic       p;
        logic [1:0] ec;
        string      tag;
        c   = (i == 0) ? col_a : col_b;
        p   = (i == 0) ? par_a : par_b;
        ec  = (i == 0) ? ec_a : ec_b;
        tag = (i == 0) ? "a" : "b";
        if (ov[i] && !prev_ov[i]) begin
            if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
                chk({tag, "_unexpected_out"}, 1, 0);
            end else begin
                e = (i == 0) ? qa.pop_front() : qb.pop_front();
                $display("[%s] out col=%0d par=%0d ec=%0d lat=%0d", tag, c, p, ec, cyc - e.acc);
                chk({tag, "_column"}, int'(c), int'(e.col));
                chk({tag, "_parity"}, int'(p), int'(e.par));
                chk({tag, "_err_class"}, int'(ec), int'(e.ec));
                chk({tag, "_latency"}, cyc - e.acc, e.lat);
                held[i] = {c, p, ec};
            end
        end else if (ov[i]) begin
            chk({tag, "_stall_stable"}, int'({c, p, ec, ir[i]}), int'({held[i], 1'b0}));
        end
        if (prev_hs[i])
            chk({tag, "_release"}, int'({ov[i], ir[i]}), 1);
        prev_ov[i] = ov[i];
        prev_hs[i] = ov[i] & ordy[i];
    endtask

    always begin
        @(negedge clk);
        #1;
        mon(0);
        mon(1);
    end

    task automatic accept(int i, logic [31:0] cw, logic [1:0] w, output int acc);
        int t = 0;
        @(negedge clk);
        while (!ir[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ir[i]) chk("accept_timeout", 0, 1);
        if (i == 0) begin cw_a = cw; w_a = w; end
        else begin cw_b = cw; w_b = w; end
        iv[i] = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        iv[i] = 1'b0;
        // Scramble inputs after acceptance: only latched values may matter.
        if (i == 0) begin cw_a = $urandom; w_a = 2'($urandom); end
        else begin cw_b = $urandom; w_b = 2'($urandom); end
    endtask

    task automatic send(int i, logic [31:0] cw, logic [1:0] w, logic [5:0] col,
                        logic par, logic [1:0] ec, int lat, int stall);
        exp_t e;
        int   acc;
        int   t;
        ordy[i] = (stall == 0);
        accept(i, cw, w, acc);
        e.col = col; e.par = par; e.ec = ec; e.lat = lat; e.acc = acc;
        if (i == 0) qa.push_back(e); else qb.push_back(e);
        $display("[%0d] in  cw=%08h w=%0d expect col=%0d par=%0d ec=%0d lat=%0d",
                 i, cw, w, col, par, ec, lat);
        t = 0;
        while (!ov[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ov[i]) chk("done_timeout", 0, 1);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            ordy[i] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        int acc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(ir[0]), 1);
        chk("rst_out_valid", int'(ov[0]), 0);
        chk("rst_column", int'(col_a), 0);
        chk("rst_parity", int'(par_a), 0);
        chk("rst_err_class", int'(ec_a), 0);

        send(0, 32'h0000_0000, 2'b10, 6'd0,  1'b0, 2'b00, 5, 0);
        send(0, 32'h0000_0020, 2'b10, 6'd6,  1'b1, 2'b01, 5, 0);
        send(0, 32'h0000_0003, 2'b10, 6'd3,  1'b0, 2'b10, 5, 0);
        send(0, 32'h0000_0083, 2'b00, 6'd11, 1'b1, 2'b11, 2, 0);
        send(0, 32'h0010_0010, 2'b00, 6'd5,  1'b1, 2'b01, 2, 0);
        send(0, 32'h8000_8000, 2'b01, 6'd16, 1'b1, 2'b01, 3, 0);
        send(0, 32'hFFFF_FFFF, 2'b11, 6'd32, 1'b0, 2'b10, 5, 0);
        send(0, 32'h8000_0000, 2'b10, 6'd32, 1'b1, 2'b01, 5, 6);

        // Reset in the second ACCUM cycle discards the in-flight codeword.
        accept(0, 32'h0000_0020, 2'b10, acc);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", int'(ir[0]), 1);
        chk("midrst_out_valid", int'(ov[0]), 0);
        chk("midrst_column", int'(col_a), 0);
        chk("midrst_err_class", int'(ec_a), 0);
        $display("[0] reset during ACCUM");
        send(0, 32'h0000_0007, 2'b10, 6'd0, 1'b1, 2'b01, 5, 0);

        send(1, 32'h0000_0020, 2'b10, 6'd6, 1'b1, 2'b01, 33, 0);
        send(1, 32'h0000_0001, 2'b00, 6'd1, 1'b1, 2'b01, 9, 0);

        repeat (4) @(negedge clk);
        chk("queues_drained", qa.size() + qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
